iic_slave: RTL

I2C slave responder: the receiving end of the `iic_opr` master link. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It acknowledges its 7-bit address, delivers written bytes as an AXI-stream master, and serves read bytes from an AXI-stream slave. SDA is driven open-drain through an output-enable. It sits between the board I2C pins and the register/config logic.

---
 rtl/iic_slave.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/iic_slave.sv
// I2C slave responder: oversampled SCL/SDA with START/STOP detection, 7-bit
// address match, write bytes out on an AXI-stream master, read bytes from an AXI-stream slave.
module iic_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tuser,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        scl_meta_q, scl_sync_q, scl_hist_q;
  logic        sda_meta_q, sda_sync_q, sda_hist_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        ack_q, ack_d;
  logic        first_q, first_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tready_q, tready_d;
  logic        stop_q, stop_d;

  logic        scl_rise, scl_fall, scl_high, start_c, stop_c;
  logic [7:0]  load_byte;

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  // SCL must be stably high for START/STOP, so an SDA edge racing an SCL edge is not misread.
  assign scl_high  = scl_sync_q & scl_hist_q;
  assign start_c   = scl_high & ~sda_sync_q & sda_hist_q;
  assign stop_c    = scl_high & sda_sync_q & ~sda_hist_q;
  assign load_byte = s_axis_tvalid ? s_axis_tdata : 8'hFF;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    ack_d    = ack_q;
    first_d  = first_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tvalid_d = 1'b0;
    tready_d = 1'b0;
    stop_d   = 1'b0;

    if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = 1'b1;
    end else if (start_c) begin
      state_d  = S_ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_sync_q};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              state_d  = S_WAIT;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              first_d  = 1'b1;
              cnt_d    = 4'd0;
              state_d  = S_WR_DATA;
            end else begin
              tx_d     = {load_byte[6:0], 1'b0};
              sda_oe_d = ~load_byte[7];
              tready_d = s_axis_tvalid;
              cnt_d    = 4'd1;
              state_d  = S_RD_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shift_d = {shift_q[6:0], sda_sync_q};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              tvalid_d = 1'b1;
              tdata_d  = {shift_q[6:0], sda_sync_q};
              tuser_d  = first_q;
              first_d  = 1'b0;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          // Falls alternate with rises, so the fall seen here follows the ACK-bit sample.
          if (scl_rise) begin
            ack_d = sda_sync_q;
          end else if (scl_fall) begin
            if (!ack_q) begin
              tx_d     = {load_byte[6:0], 1'b0};
              sda_oe_d = ~load_byte[7];
              tready_d = s_axis_tvalid;
              cnt_d    = 4'd1;
              state_d  = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      tready_q   <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tuser_q    <= tuser_d;
      tready_q   <= tready_d;
      stop_q     <= stop_d;
    end
  end

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign s_axis_tready = tready_q;
  assign stop_det      = stop_q;

endmodule
